// File: rtl/aes128_pkg.sv
// Shared types and constants for the AES-128 AFU datapath.
package aes128_pkg;

    localparam int AES_BLOCK_W         = 128;
    localparam int AES_BLOCKS_PER_LINE = 4;
    localparam int CL_LINE_W           = AES_BLOCK_W * AES_BLOCKS_PER_LINE;

    typedef logic [127:0] t_aes_block;
    typedef logic [511:0] t_cl_line;

endpackage

// File: rtl/aes128_line_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// The caller guarantees push only when !full or a pop happens in the same
// cycle, and pop only when !empty. pop_data shows the head entry and reads
// as zero while the FIFO is empty.
module aes128_line_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage array: no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally; occupancy alone distinguishes full from empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/aes128_line_packer.sv
// Packs 128-bit cipher blocks into 512-bit cache lines and buffers them.
// Handshake: valid_in has no ready (every valid block is taken); a line moves
// out on any cycle where line_valid && line_ready, and line_out holds steady
// while line_valid is high and line_ready is low.
module aes128_line_packer
    import aes128_pkg::*;
#(
    parameter int LINE_DEPTH     = 8,
    parameter int ALMFULL_MARGIN = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [127:0]                      data_in,
    input  logic                              valid_in,
    input  logic                              flush_in,
    output logic [511:0]                      line_out,
    output logic                              line_valid,
    input  logic                              line_ready,
    output logic                              almost_full,
    output logic [$clog2(LINE_DEPTH+1)-1:0]   line_count,
    output logic                              overflow_err
);

    localparam int CW     = $clog2(LINE_DEPTH+1);
    localparam int LANE_W = $clog2(AES_BLOCKS_PER_LINE);

    logic [LANE_W-1:0] lane_idx;
    t_cl_line          staging;
    t_cl_line          line_next;
    logic              push_req;
    logic              do_push;
    logic              do_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CW-1:0]     count_next;
    logic              almost_full_next;

    // Staging line with the incoming block merged into its lane.
    always_comb begin
        line_next = staging;
        for (int i = 0; i < AES_BLOCKS_PER_LINE; i++) begin
            if (valid_in && lane_idx == LANE_W'(i)) begin
                line_next[i*AES_BLOCK_W +: AES_BLOCK_W] = data_in;
            end
        end
    end

    // A line completes on the last lane, or on flush when anything is staged.
    assign push_req = (valid_in && lane_idx == LANE_W'(AES_BLOCKS_PER_LINE-1)) ||
                      (flush_in && (valid_in || lane_idx != '0));
    assign line_valid = !fifo_empty;
    assign do_pop     = line_valid && line_ready;
    assign do_push    = push_req && (!fifo_full || do_pop);

    // Occupancy after this cycle, used to register the throttle flag.
    always_comb begin
        count_next = line_count;
        if (do_push && !do_pop) begin
            count_next = line_count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_next = line_count - CW'(1);
        end
    end

    assign almost_full_next = (LINE_DEPTH - int'(count_next)) <= ALMFULL_MARGIN;

    // Lane accumulator: clearing on push zero-fills lanes a flush leaves unused.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_idx <= '0;
            staging  <= '0;
        end else if (push_req) begin
            lane_idx <= '0;
            staging  <= '0;
        end else if (valid_in) begin
            lane_idx <= lane_idx + LANE_W'(1);
            staging  <= line_next;
        end
    end

    // Registered throttle flag and sticky drop indicator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            almost_full  <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            almost_full <= almost_full_next;
            if (push_req && !do_push) begin
                overflow_err <= 1'b1;
            end
        end
    end

    aes128_line_fifo #(
        .WIDTH (CL_LINE_W),
        .DEPTH (LINE_DEPTH)
    ) u_line_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (do_push),
        .push_data (line_next),
        .pop       (do_pop),
        .pop_data  (line_out),
        .count     (line_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_aes128_line_packer.sv
// Bench for aes128_line_packer: directed scenarios plus a randomized run,
// checked against a queue-based packing model through a scoreboard.
module tb_aes128_line_packer;

    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;
    localparam int CW     = $clog2(DEPTH+1);

    logic           clk = 1'b0;
    logic           reset;
    logic [127:0]   data_in;
    logic           valid_in;
    logic           flush_in;
    logic [511:0]   line_out;
    logic           line_valid;
    logic           line_ready;
    logic           almost_full;
    logic [CW-1:0]  line_count;
    logic           overflow_err;

    aes128_line_packer #(
        .LINE_DEPTH     (DEPTH),
        .ALMFULL_MARGIN (MARGIN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .flush_in     (flush_in),
        .line_out     (line_out),
        .line_valid   (line_valid),
        .line_ready   (line_ready),
        .almost_full  (almost_full),
        .line_count   (line_count),
        .overflow_err (overflow_err)
    );

    // Clock and reset control
    always #5 clk = ~clk;

    int           errors = 0;
    int           checks = 0;
    logic [511:0] exp_q[$];
    logic [127:0] pend[$];
    int           cur_count = 0;
    int           nxt_count = 0;
    bit           cur_ovf = 0;
    bit           nxt_ovf = 0;
    bit           in_reset = 1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_line_out"}, line_out, '0);
        check({tag, "_line_valid"}, 512'(line_valid), '0);
        check({tag, "_line_count"}, 512'(line_count), '0);
        check({tag, "_almost_full"}, 512'(almost_full), '0);
        check({tag, "_overflow_err"}, 512'(overflow_err), '0);
    endtask

    // Driver: applies one cycle of stimulus and advances the reference model.
    task automatic step(input bit v, input logic [127:0] d, input bit f, input bit r);
        logic [511:0] line;
        bit push_req;
        bit pop;
        bit acc;
        @(posedge clk);
        #1;
        cur_count  = nxt_count;
        cur_ovf    = nxt_ovf;
        valid_in   = v;
        data_in    = d;
        flush_in   = f;
        line_ready = r;
        if (v) pend.push_back(d);
        push_req = (pend.size() == 4) || (f && pend.size() > 0);
        pop      = (cur_count > 0) && r;
        acc      = 0;
        if (push_req) begin
            line = '0;
            foreach (pend[i]) line[i*128 +: 128] = pend[i];
            pend.delete();
            if (cur_count < DEPTH || pop) begin
                exp_q.push_back(line);
                acc = 1;
            end else begin
                nxt_ovf = 1;
            end
        end
        nxt_count = cur_count + int'(acc) - int'(pop);
    endtask

    task automatic rand_block(output logic [127:0] d);
        d = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        reset      = 1'b1;
        in_reset   = 1;
        valid_in   = 1'b0;
        flush_in   = 1'b0;
        line_ready = 1'b0;
        #1;
        check_all_zero("async_reset");
        pend.delete();
        exp_q.delete();
        cur_count = 0;
        nxt_count = 0;
        cur_ovf   = 0;
        nxt_ovf   = 0;
        @(negedge clk);
        #2;
        reset    = 1'b0;
        in_reset = 0;
    endtask

    task automatic drain();
        int guard = 0;
        step(0, '0, 1, 1);
        while ((exp_q.size() > 0 || nxt_count > 0) && guard < 200) begin
            step(0, '0, 0, 1);
            guard++;
        end
        checks++;
        if (exp_q.size() != 0 || nxt_count != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d lines left expected 0", exp_q.size());
        end
        step(0, '0, 0, 1);
    endtask

    // Scoreboard monitor: samples mid-cycle, pops the expected queue on a handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!in_reset) begin
                check("line_count", 512'(line_count), 512'(cur_count));
                check("line_valid", 512'(line_valid), 512'(cur_count > 0));
                check("almost_full", 512'(almost_full), 512'((DEPTH - cur_count) <= MARGIN));
                check("overflow_err", 512'(overflow_err), 512'(cur_ovf));
                if (line_valid && line_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_line: got %0h expected none", line_out);
                    end else begin
                        check("line_out", line_out, exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Stimulus sequence
    initial begin
        logic [127:0] d;
        int sent;
        bit v;
        bit f;
        bit r;
        reset      = 1'b1;
        valid_in   = 1'b0;
        flush_in   = 1'b0;
        line_ready = 1'b0;
        data_in    = '0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        @(negedge clk);
        #2;
        reset    = 1'b0;
        in_reset = 0;

        // Four consecutive blocks form one line
        for (int i = 1; i <= 4; i++) step(1, 128'(i), 0, 1);
        repeat (3) step(0, '0, 0, 1);

        // Partial line flush, then an empty flush
        step(1, 128'h11, 0, 1);
        step(1, 128'h12, 0, 1);
        step(0, '0, 1, 1);
        step(0, '0, 0, 1);
        step(0, '0, 1, 1);
        repeat (2) step(0, '0, 0, 1);

        // Flush coinciding with a block
        step(1, 128'h31, 0, 1);
        step(1, 128'h32, 1, 1);
        repeat (2) step(0, '0, 0, 1);

        // Fill to capacity with no consumer, ninth line is dropped
        for (int l = 0; l < 9; l++) begin
            for (int j = 0; j < 4; j++) begin
                rand_block(d);
                step(1, d, 0, 0);
            end
        end
        repeat (2) step(0, '0, 0, 0);
        drain();
        async_reset();

        // Full FIFO, completing line coincides with a pop
        for (int l = 0; l < 8; l++) begin
            for (int j = 0; j < 4; j++) begin
                rand_block(d);
                step(1, d, 0, 0);
            end
        end
        for (int j = 0; j < 3; j++) begin
            rand_block(d);
            step(1, d, 0, 0);
        end
        rand_block(d);
        step(1, d, 0, 1);
        step(0, '0, 0, 0);
        drain();

        // Asynchronous reset with stored lines and a partial line
        for (int j = 0; j < 14; j++) begin
            rand_block(d);
            step(1, d, 0, 0);
        end
        async_reset();
        for (int i = 0; i < 4; i++) step(1, 128'h21 + 128'(i), 0, 1);
        repeat (3) step(0, '0, 0, 1);

        // Randomized traffic with the throttle honoured
        sent = 0;
        while (sent < 10000) begin
            v = ((DEPTH - nxt_count) > MARGIN) && ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 31) == 0);
            r = ($urandom_range(0, 1) == 1);
            rand_block(d);
            step(v, d, f, r);
            if (v) sent++;
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
